fetch_link_ctrl: RTL and testbench
==================================

# fetch_link_ctrl

Transaction controller for the fetch serial link. It accepts a fetch request carrying a 16-bit command, hands the command to the link transmitter, and waits for the 16-bit response word from the link receiver. It retries on timeout or bad response, then reports the result or an error. It also owns the bit-period configuration, driving `tbit_period` to both the transmitter and the receiver from a 2-bit baud select.

## Interface
**Parameters**
- `RETRY_MAX`, default 3: retries after the first attempt before reporting failure (range 0..3).
- `TIMEOUT_BITS`, default 40: response timeout, in bit periods, counted from the end of transmit.

**Ports**
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_start`  in  1  single-cycle request pulse; honoured only in IDLE.
- `fetch_cmd`  in  16  command word; sampled with `fetch_start`.
- `baud_sel`  in  2  bit-rate select; sampled with `fetch_start`.
- `tbit_period`  out  20  clocks per bit, shared by the transmitter and receiver.
- `tx_req`  out  1  transmit request; held high until `tx_done`.
- `tx_data`  out  16  word to transmit; stable while `tx_req` is high.
- `tx_done`  in  1  single-cycle pulse from the transmitter after its stop bit.
- `rx_vld`  in  1  single-cycle pulse from the receiver.
- `rx_data`  in  16  received word; valid with `rx_vld`.
- `fetch_busy`  out  1  high in every state except IDLE.
- `fetch_vld`  out  1  single-cycle pulse: good response captured.
- `fetch_data`  out  16  last good response; held until the next success.
- `fetch_err`  out  1  single-cycle pulse: retries exhausted.
- `retry_cnt`  out  2  retries used by the current or last transaction.

## Operation
**Bit-period lookup** (`baud_sel`): 0→868, 1→434, 2→217, 3→108. These are the 115200/230400/460800/921600 rates at 100 MHz. The selected value is latched on an accepted `fetch_start` and is constant for the whole transaction.

**State machine**

| State | Behaviour | Exit |
|---|---|---|
| IDLE | Waits for `fetch_start`. | On `fetch_start`: latch `fetch_cmd`, latch `baud_sel`, clear `retry_cnt`, go to SEND. |
| SEND | `tx_req`=1, `tx_data`=latched command. | On `tx_done`: go to WAIT and clear the timeout counters. |
| WAIT | Runs the timeout counters. | On `rx_vld`: capture `rx_data` and go to CHECK. On timeout: go to RETRY. |
| CHECK | Evaluates the captured response. | Good response: go to DONE. Bad response: go to RETRY. |
| RETRY | Decides whether to try again. | If `retry_cnt`==`RETRY_MAX`: go to FAIL. Otherwise increment `retry_cnt` and go to SEND. |
| DONE | `fetch_data` ← captured word, `fetch_vld`=1. | Go to IDLE. |
| FAIL | `fetch_err`=1; `fetch_data` is unchanged. | Go to IDLE. |

**Timeout counters**
- Cycle counter: 20 bits, wraps at `tbit_period`−1.
- Bit counter: increments on each wrap. Timeout is asserted when the bit counter reaches `TIMEOUT_BITS`, i.e. after exactly `TIMEOUT_BITS`×`tbit_period` cycles in WAIT.

**Boundary rules**
- `fetch_start` is ignored while busy.
- `rx_vld` is ignored outside WAIT.
- `tx_done` is ignored outside SEND.
- If `rx_vld` and timeout occur in the same cycle, `rx_vld` wins.
- `tx_done` arriving in the first SEND cycle is accepted.
- Reset mid-transaction aborts immediately: return to IDLE with no `fetch_vld` or `fetch_err`. The transmitter sees `tx_req` fall asynchronously.

## Timing
**Reset values**
- `tbit_period`=868
- `tx_req`=0
- `tx_data`=0
- `fetch_busy`=0
- `fetch_vld`=0
- `fetch_err`=0
- `fetch_data`=0
- `retry_cnt`=0
- state IDLE

All outputs are registered.

**Cycle timing**
- `fetch_start` at cycle 0 → `fetch_busy`, `tx_req` and `tbit_period` update at cycle 1.
- `tx_done` at cycle k → `tx_req` low at k+1.
- `rx_vld` at cycle m → CHECK at m+1 → `fetch_vld` and `fetch_data` at m+2. `fetch_busy` is still high at m+2 and low at m+3.
- A timeout detected at cycle t → RETRY at t+1 → SEND (`tx_req` high) at t+2.
- Minimum spacing between transactions: the next `fetch_start` is accepted one cycle after DONE or FAIL.

## Configuration
`FETCH_LINK_CTRL_ECHO_CHK_EN`
- **Defined:** a response is good only if `rx_data[15:8]` equals `fetch_cmd[15:8]`. A mismatch goes through RETRY and consumes a retry.
- **Undefined:** every `rx_vld` in WAIT is good. The comparison logic is removed, and CHECK always goes to DONE.

## Test plan
1. **Normal fetch.** `baud_sel`=2, `fetch_cmd`=0xA512; `tx_done` after 10 cycles; `rx_vld` with 0xA5C3 20 cycles later. Expect `tbit_period`=217, `tx_data`=0xA512, and `fetch_vld` pulse with `fetch_data`=0xA5C3 two cycles after `rx_vld`. Expect `retry_cnt`=0.
2. **Timeout with recovery.** `baud_sel`=3, `TIMEOUT_BITS`=40; no response. Expect `tx_req` to re-rise exactly 4320+2 cycles after `tx_done`. Then answer correctly and expect `fetch_vld` with `retry_cnt`=1.
3. **Retries exhausted.** Never respond, `RETRY_MAX`=3. Expect 4 `tx_req` assertions, then a `fetch_err` pulse with `retry_cnt`=3. `fetch_data` keeps its previous value.
4. **Echo check (ECHO_CHK_EN defined).** `fetch_cmd`=0x3300; respond 0x4401, then 0x3301. Expect one retry, then `fetch_data`=0x3301. With the macro undefined, expect `fetch_data`=0x4401 and no retry.
5. **Ignore and collision.** `fetch_start` with `baud_sel`=0 while busy; `rx_vld` during SEND; `rx_vld` in the same cycle as timeout. Expect the second start to be ignored, `tbit_period` to stay at the first value, the stray `rx_vld` to be dropped, and the collision to resolve as success.
6. **Reset mid-transaction.** Assert `rst_n` low during WAIT. Expect all outputs at their reset values, including `tbit_period`=868 and `fetch_busy`=0. The next `fetch_start` completes normally.

Source files
------------

// File: rtl/fetch_link_ctrl_if.sv
// Fetch link controller bundle: request, transmitter, receiver and result.
// master = requester/PHY side, slave = fetch_link_ctrl.
interface fetch_link_ctrl_if;
    logic        fetch_start;
    logic [15:0] fetch_cmd;
    logic [1:0]  baud_sel;
    logic [19:0] tbit_period;
    logic        tx_req;
    logic [15:0] tx_data;
    logic        tx_done;
    logic        rx_vld;
    logic [15:0] rx_data;
    logic        fetch_busy;
    logic        fetch_vld;
    logic [15:0] fetch_data;
    logic        fetch_err;
    logic [1:0]  retry_cnt;

    modport master (
        output fetch_start, fetch_cmd, baud_sel, tx_done, rx_vld, rx_data,
        input  tbit_period, tx_req, tx_data, fetch_busy, fetch_vld,
        input  fetch_data, fetch_err, retry_cnt
    );

    modport slave (
        input  fetch_start, fetch_cmd, baud_sel, tx_done, rx_vld, rx_data,
        output tbit_period, tx_req, tx_data, fetch_busy, fetch_vld,
        output fetch_data, fetch_err, retry_cnt
    );
endinterface

// File: rtl/fetch_link_ctrl.sv
// Fetch serial-link transaction controller: send command, await response,
// retry on timeout/bad echo, report result; owns the bit-period setting.
// Ports: clk_sys, rst_n (async, active-low), bus (fetch_link_ctrl_if.slave).
// Option: FETCH_LINK_CTRL_ECHO_CHK_EN enables response high-byte echo check.
module fetch_link_ctrl #(
    parameter int unsigned RETRY_MAX    = 3,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input logic              clk_sys,
    input logic              rst_n,
    fetch_link_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEND  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] RETRY = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] FAIL  = 3'd6;

    localparam int BW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(TIMEOUT_BITS - 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [15:0]   rsp_q, rsp_d;
    logic [15:0]   data_q, data_d;
    logic [19:0]   tbit_q, tbit_d;
    logic [19:0]   cyc_q, cyc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [1:0]    retry_q, retry_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic          tx_req_q, busy_q;
    logic [19:0]   tbit_sel;
    logic          wrap, timeout, good;

    always_comb begin
        tbit_sel = 20'd868;
        case (bus.baud_sel)
            2'd1:    tbit_sel = 20'd434;
            2'd2:    tbit_sel = 20'd217;
            2'd3:    tbit_sel = 20'd108;
            default: tbit_sel = 20'd868;
        endcase
    end

    // Timeout fires on the last wrap, so WAIT lasts TIMEOUT_BITS*tbit cycles.
    assign wrap    = (cyc_q == tbit_q - 20'd1);
    assign timeout = wrap && (bit_q == BIT_LAST);

`ifdef FETCH_LINK_CTRL_ECHO_CHK_EN
    assign good = (rsp_q[15:8] == cmd_q[15:8]);
`else
    assign good = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rsp_d   = rsp_q;
        data_d  = data_q;
        tbit_d  = tbit_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        retry_d = retry_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fetch_start) begin
                    cmd_d   = bus.fetch_cmd;
                    tbit_d  = tbit_sel;
                    retry_d = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.tx_done) begin
                    cyc_d   = 20'd0;
                    bit_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // rx_vld has priority over a coincident timeout
                if (bus.rx_vld) begin
                    rsp_d   = bus.rx_data;
                    state_d = CHECK;
                end else if (timeout) begin
                    state_d = RETRY;
                end else if (wrap) begin
                    cyc_d = 20'd0;
                    bit_d = bit_q + 1'b1;
                end else begin
                    cyc_d = cyc_q + 20'd1;
                end
            end
            CHECK: begin
                if (good) begin
                    data_d  = rsp_q;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RETRY;
                end
            end
            RETRY: begin
                if (retry_q == 2'(RETRY_MAX)) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end else begin
                    retry_d = retry_q + 2'd1;
                    state_d = SEND;
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= 16'd0;
            rsp_q    <= 16'd0;
            data_q   <= 16'd0;
            tbit_q   <= 20'd868;
            cyc_q    <= 20'd0;
            bit_q    <= '0;
            retry_q  <= 2'd0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            tx_req_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rsp_q    <= rsp_d;
            data_q   <= data_d;
            tbit_q   <= tbit_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            retry_q  <= retry_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            tx_req_q <= (state_d == SEND);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign bus.tbit_period = tbit_q;
    assign bus.tx_req      = tx_req_q;
    assign bus.tx_data     = cmd_q;
    assign bus.fetch_busy  = busy_q;
    assign bus.fetch_vld   = vld_q;
    assign bus.fetch_data  = data_q;
    assign bus.fetch_err   = err_q;
    assign bus.retry_cnt   = retry_q;
endmodule

// File: tb/tb_fetch_link_ctrl.sv
// Self-checking bench for fetch_link_ctrl: vector table of normal fetches
// plus directed timeout, retry, echo, collision and reset sequences.
module tb_fetch_link_ctrl;
    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    fetch_link_ctrl_if bus ();

    fetch_link_ctrl #(.RETRY_MAX(3), .TIMEOUT_BITS(40)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0]  baud;
        logic [15:0] cmd;
        logic [15:0] rsp;
        int          txd;
        int          rxd;
        logic [19:0] tbit;
    } vec_t;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [15:0] c, input logic [1:0] b);
        bus.fetch_cmd   = c;
        bus.baud_sel    = b;
        bus.fetch_start = 1'b1;
        tick();
        bus.fetch_start = 1'b0;
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic pulse_rx(input logic [15:0] d);
        bus.rx_data = d;
        bus.rx_vld  = 1'b1;
        tick();
        bus.rx_vld  = 1'b0;
    endtask

    task automatic wait_req(input int lim, output int n);
        n = 1;
        while (!bus.tx_req && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tbit"},  bus.tbit_period, 20'd868);
        chk({tag, "_txreq"}, bus.tx_req, 1'b0);
        chk({tag, "_txdat"}, bus.tx_data, 16'h0);
        chk({tag, "_busy"},  bus.fetch_busy, 1'b0);
        chk({tag, "_vld"},   bus.fetch_vld, 1'b0);
        chk({tag, "_err"},   bus.fetch_err, 1'b0);
        chk({tag, "_data"},  bus.fetch_data, 16'h0);
        chk({tag, "_retry"}, bus.retry_cnt, 2'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v[4];
        int          n;
        int          reqs;
        logic [15:0] prev;

        v[0] = '{2'd2, 16'hA512, 16'hA5C3, 10, 20, 20'd217};
        v[1] = '{2'd0, 16'h0F0F, 16'h0F00, 0, 0, 20'd868};
        v[2] = '{2'd1, 16'hFFFF, 16'hFF01, 3, 7, 20'd434};
        v[3] = '{2'd3, 16'h0001, 16'h0000, 1, 2, 20'd108};

        bus.fetch_start = 1'b0;
        bus.fetch_cmd   = 16'h0;
        bus.baud_sel    = 2'd0;
        bus.tx_done     = 1'b0;
        bus.rx_vld      = 1'b0;
        bus.rx_data     = 16'h0;

        repeat (3) tick();
        chk_reset("rst0");
        rst_n = 1'b1;
        tick();

        // Table of normal fetches, back-to-back
        foreach (v[i]) begin
            start(v[i].cmd, v[i].baud);
            chk($sformatf("v%0d_tbit", i), bus.tbit_period, v[i].tbit);
            chk($sformatf("v%0d_txdat", i), bus.tx_data, v[i].cmd);
            chk($sformatf("v%0d_txreq", i), bus.tx_req, 1'b1);
            chk($sformatf("v%0d_busy", i), bus.fetch_busy, 1'b1);
            repeat (v[i].txd) tick();
            pulse_done();
            chk($sformatf("v%0d_txreq_lo", i), bus.tx_req, 1'b0);
            repeat (v[i].rxd) tick();
            pulse_rx(v[i].rsp);
            chk($sformatf("v%0d_vld_early", i), bus.fetch_vld, 1'b0);
            tick();
            chk($sformatf("v%0d_vld", i), bus.fetch_vld, 1'b1);
            chk($sformatf("v%0d_data", i), bus.fetch_data, v[i].rsp);
            chk($sformatf("v%0d_retry", i), bus.retry_cnt, 2'd0);
            chk($sformatf("v%0d_busy_done", i), bus.fetch_busy, 1'b1);
            tick();
            chk($sformatf("v%0d_vld_lo", i), bus.fetch_vld, 1'b0);
            chk($sformatf("v%0d_busy_lo", i), bus.fetch_busy, 1'b0);
            chk($sformatf("v%0d_hold", i), bus.fetch_data, v[i].rsp);
        end

        // Timeout then recovery
        start(16'h1234, 2'd3);
        pulse_done();
        wait_req(5000, n);
        chk("to_gap", n, 4322);
        chk("to_retry", bus.retry_cnt, 2'd1);
        pulse_done();
        pulse_rx(16'h12AA);
        tick();
        chk("to_vld", bus.fetch_vld, 1'b1);
        chk("to_data", bus.fetch_data, 16'h12AA);
        chk("to_retry2", bus.retry_cnt, 2'd1);
        tick();

        // Retries exhausted
        prev = 16'h12AA;
        reqs = 0;
        start(16'h5555, 2'd3);
        for (int i = 0; i < 4; i++) begin
            wait_req(5000, n);
            if (bus.tx_req) begin
                reqs++;
                pulse_done();
            end
        end
        chk("ex_reqs", reqs, 4);
        n = 1;
        while (!bus.fetch_err && n < 5000) begin
            tick();
            n++;
        end
        chk("ex_err", bus.fetch_err, 1'b1);
        chk("ex_err_gap", n, 4322);
        chk("ex_retry", bus.retry_cnt, 2'd3);
        chk("ex_data", bus.fetch_data, prev);
        chk("ex_vld", bus.fetch_vld, 1'b0);
        tick();
        chk("ex_err_lo", bus.fetch_err, 1'b0);
        chk("ex_busy_lo", bus.fetch_busy, 1'b0);
        chk("ex_txreq_lo", bus.tx_req, 1'b0);

        // Echo check
        start(16'h3300, 2'd2);
        pulse_done();
        pulse_rx(16'h4401);
        tick();
`ifdef FETCH_LINK_CTRL_ECHO_CHK_EN
        chk("echo_vld_bad", bus.fetch_vld, 1'b0);
        tick();
        chk("echo_resend", bus.tx_req, 1'b1);
        chk("echo_retry", bus.retry_cnt, 2'd1);
        pulse_done();
        pulse_rx(16'h3301);
        tick();
        chk("echo_vld", bus.fetch_vld, 1'b1);
        chk("echo_data", bus.fetch_data, 16'h3301);
`else
        chk("echo_vld", bus.fetch_vld, 1'b1);
        chk("echo_data", bus.fetch_data, 16'h4401);
        chk("echo_retry", bus.retry_cnt, 2'd0);
`endif
        tick();

        // Ignored start, stray rx_vld, rx/timeout collision
        start(16'h7E01, 2'd3);
        start(16'h0000, 2'd0);
        chk("ign_tbit", bus.tbit_period, 20'd108);
        chk("ign_txdat", bus.tx_data, 16'h7E01);
        pulse_rx(16'h7EFF);
        chk("stray_txreq", bus.tx_req, 1'b1);
        pulse_done();
        repeat (4319) tick();
        pulse_rx(16'h7E42);
        chk("col_txreq", bus.tx_req, 1'b0);
        tick();
        chk("col_vld", bus.fetch_vld, 1'b1);
        chk("col_data", bus.fetch_data, 16'h7E42);
        chk("col_retry", bus.retry_cnt, 2'd0);
        tick();

        // Reset during WAIT
        start(16'h9001, 2'd2);
        pulse_done();
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst1");
        tick();
        tick();
        chk("rst1_vld", bus.fetch_vld, 1'b0);
        chk("rst1_err", bus.fetch_err, 1'b0);
        rst_n = 1'b1;
        tick();
        start(16'h9002, 2'd2);
        chk("post_tbit", bus.tbit_period, 20'd217);
        chk("post_txdat", bus.tx_data, 16'h9002);
        pulse_done();
        pulse_rx(16'h90BE);
        tick();
        chk("post_vld", bus.fetch_vld, 1'b1);
        chk("post_data", bus.fetch_data, 16'h90BE);
        tick();
        chk("post_busy", bus.fetch_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
